// File: rtl/adder_scheduler.sv
// Round-robin scheduler sharing one N-bit ripple adder among R requesters.
// Subtraction takes two adder passes: negate B, then add.
module adder_scheduler #(
  parameter int unsigned N = 8,
  parameter int unsigned R = 4,
  localparam int unsigned IW = (R > 1) ? $clog2(R) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [R-1:0]    req_valid,
  output logic [R-1:0]    req_ready,
  input  logic [R*N-1:0]  req_a,
  input  logic [R*N-1:0]  req_b,
  input  logic [R-1:0]    req_sub,
  output logic            res_valid,
  output logic [N-1:0]    res_data,
  output logic            res_carry,
  output logic [IW-1:0]   res_id,
  input  logic            res_ready
);

  typedef enum logic [1:0] {IDLE, NEG, ADD, HOLD} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] id_reg;
  logic [IW-1:0] grant;
  logic          found;
  int unsigned   idx;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic          sub_reg;
  logic          neg_c;
  logic [N-1:0]  sel_a;
  logic [N-1:0]  sel_b;
  logic          sel_sub;
  logic [N-1:0]  add_a;
  logic [N-1:0]  add_b;
  logic          add_cin;
  logic [N-1:0]  add_sum;
  logic          add_cout;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= R; k++) begin
      idx = (32'(ptr) + k) % R;
      if (!found && req_valid[IW'(idx)]) begin
        found = 1'b1;
        grant = IW'(idx);
      end
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int unsigned i = 0; i < R; i++) begin
      if (grant == IW'(i)) begin
        sel_a   = req_a[i*N +: N];
        sel_b   = req_b[i*N +: N];
        sel_sub = req_sub[i];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !reset && found) begin
      req_ready[grant] = 1'b1;
    end
  end

  // NEG pass computes ~B + 1; every other state feeds A + Breg.
  always_comb begin
    add_a   = (state == NEG) ? ~b_reg : a_reg;
    add_b   = (state == NEG) ? '0 : b_reg;
    add_cin = (state == NEG);
  end

  N_bit_adder #(.N(N)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= IW'(R - 1);
      id_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      neg_c     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            a_reg   <= sel_a;
            b_reg   <= sel_b;
            sub_reg <= sel_sub;
            id_reg  <= grant;
            ptr     <= grant;
            neg_c   <= 1'b0;
            state   <= sel_sub ? NEG : ADD;
          end
        end
        NEG: begin
          b_reg <= add_sum;
          neg_c <= add_cout;
          state <= ADD;
        end
        ADD: begin
          res_data  <= add_sum;
          // B = 0 negates to 0 with a carry; that case is still "no borrow".
          res_carry <= sub_reg ? (add_cout | neg_c) : add_cout;
          res_id    <= id_reg;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// Plain ripple-carry adder: sum = a + b + cin.
module N_bit_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: tb/tb_adder_scheduler.sv
// Directed self-checking bench for adder_scheduler (N=8, R=4).
module tb_adder_scheduler;

  localparam int unsigned N = 8;
  localparam int unsigned R = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R-1:0]   req_sub;
  logic           res_valid;
  logic [N-1:0]   res_data;
  logic           res_carry;
  logic [1:0]     res_id;
  logic           res_ready;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  adder_scheduler #(.N(N), .R(R)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic s);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_sub[i]      = s;
  endtask

  // Issues one request from requester i alone and returns what came out.
  task automatic run_one(input int i, input logic [7:0] a, input logic [7:0] b, input logic s,
                         output int lat, output logic [7:0] d, output logic c, output logic [1:0] id);
    int w;
    w = 0; lat = 99; d = '0; c = 1'b0; id = '0;
    set_req(i, a, b, s);
    res_ready = 1'b1;
    req_valid = '0;
    req_valid[i] = 1'b1;
    #1;
    while (!req_ready[i] && w < 10) begin
      tick();
      w++;
    end
    if (!req_ready[i]) begin
      req_valid = '0;
      return;
    end
    tick();
    req_valid[i] = 1'b0;
    req_a = ~req_a;
    req_b = ~req_b;
    req_sub = ~req_sub;
    lat = 1;
    while (!res_valid && lat < 10) begin
      tick();
      lat++;
    end
    d = res_data; c = res_carry; id = res_id;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1; res_ready = 1'b0;
    req_a = '0; req_b = '0; req_sub = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
      n_checks++;
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
      n_checks++;
      if (res_data !== 8'h00) begin n_fail++; $display("FAIL reset_res_data: got %h expected 00", res_data); end
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL first_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0; res_ready = 1'b1;
    tick();
    n_checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd0) begin
      n_fail++; $display("FAIL first_result: got valid=%b id=%0d expected valid=1 id=0", res_valid, res_id);
    end
    tick();
  endtask

  task automatic test_add();
    int lat; logic [7:0] d; logic c; logic [1:0] id;
    run_one(1, 8'h7F, 8'h01, 1'b0, lat, d, c, id);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d expected 2", lat); end
    n_checks++;
    if ({d, c, id} !== {8'h80, 1'b0, 2'd1}) begin
      n_fail++; $display("FAIL add_7f_01: got data=%h carry=%b id=%0d expected 80/0/1", d, c, id);
    end
    run_one(1, 8'hFF, 8'h02, 1'b0, lat, d, c, id);
    n_checks++;
    if ({d, c, id} !== {8'h01, 1'b1, 2'd1}) begin
      n_fail++; $display("FAIL add_ff_02: got data=%h carry=%b id=%0d expected 01/1/1", d, c, id);
    end
  endtask

  task automatic test_sub();
    int lat; logic [7:0] d; logic c; logic [1:0] id;
    run_one(2, 8'h05, 8'h07, 1'b1, lat, d, c, id);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL sub_latency: got %0d expected 3", lat); end
    n_checks++;
    if ({d, c, id} !== {8'hFE, 1'b0, 2'd2}) begin
      n_fail++; $display("FAIL sub_05_07: got data=%h carry=%b id=%0d expected fe/0/2", d, c, id);
    end
    run_one(3, 8'h09, 8'h00, 1'b1, lat, d, c, id);
    n_checks++;
    if ({d, c, id} !== {8'h09, 1'b1, 2'd3}) begin
      n_fail++; $display("FAIL sub_09_00: got data=%h carry=%b id=%0d expected 09/1/3", d, c, id);
    end
    run_one(0, 8'h07, 8'h07, 1'b1, lat, d, c, id);
    n_checks++;
    if ({d, c, id} !== {8'h00, 1'b1, 2'd0}) begin
      n_fail++; $display("FAIL sub_07_07: got data=%h carry=%b id=%0d expected 00/1/0", d, c, id);
    end
  endtask

  task automatic test_round_robin();
    int exp_id[6] = '{0, 1, 2, 3, 0, 1};
    int t[3];
    int w;
    reset = 1'b1; req_valid = '0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 8'(8'h10 + i), 8'h01, 1'b0);
    res_ready = 1'b1;
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      while (!res_valid && w < 10) begin tick(); w++; end
      n_checks++;
      if (res_valid !== 1'b1 || res_id !== 2'(exp_id[k])) begin
        n_fail++; $display("FAIL rr_id[%0d]: got valid=%b id=%0d expected id=%0d", k, res_valid, res_id, exp_id[k]);
      end
      n_checks++;
      if (res_data !== 8'(8'h11 + exp_id[k])) begin
        n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", k, res_data, 8'(8'h11 + exp_id[k]));
      end
      if (k == 5) req_valid = 4'b0100;
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      w = 0;
      while (!res_valid && w < 10) begin tick(); w++; end
      t[j] = cyc;
      n_checks++;
      if (res_valid !== 1'b1 || res_id !== 2'd2) begin
        n_fail++; $display("FAIL solo_req2_id[%0d]: got valid=%b id=%0d expected id=2", j, res_valid, res_id);
      end
      if (j == 2) req_valid = '0;
      tick();
    end
    n_checks++;
    if (t[1] - t[0] !== 3 || t[2] - t[1] !== 3) begin
      n_fail++; $display("FAIL solo_req2_period: got %0d,%0d expected 3,3", t[1] - t[0], t[2] - t[1]);
    end
  endtask

  task automatic test_backpressure();
    int w;
    res_ready = 1'b0;
    set_req(3, 8'h30, 8'h0C, 1'b0);
    req_valid = 4'b1000;
    #1;
    w = 0;
    while (!req_ready[3] && w < 10) begin tick(); w++; end
    tick();
    req_valid = 4'hF;
    req_a = '0; req_b = '0;
    w = 0;
    while (!res_valid && w < 10) begin tick(); w++; end
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if ({res_valid, res_data, res_carry, res_id} !== {1'b1, 8'h3C, 1'b0, 2'd3}) begin
        n_fail++; $display("FAIL hold_stable[%0d]: got valid=%b data=%h carry=%b id=%0d expected 1/3c/0/3",
                           k, res_valid, res_data, res_carry, res_id);
      end
      n_checks++;
      if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL hold_req_ready[%0d]: got %b expected 0000", k, req_ready); end
      tick();
    end
    res_ready = 1'b1;
    tick();
    req_valid = '0;
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL release: got valid=%b expected 0", res_valid); end
  endtask

  task automatic test_reset_mid();
    int w; int lat;
    res_ready = 1'b1;
    set_req(1, 8'h20, 8'h01, 1'b1);
    req_valid = 4'b0010;
    #1;
    w = 0;
    while (!req_ready[1] && w < 10) begin tick(); w++; end
    tick();
    reset = 1'b1; req_valid = '0;
    tick();
    n_checks++;
    if (res_valid !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL mid_reset_outputs: got valid=%b ready=%b expected 0/0000", res_valid, req_ready);
    end
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_stale[%0d]: got valid=%b expected 0", k, res_valid); end
      tick();
    end
    set_req(1, 8'h40, 8'h05, 1'b1);
    set_req(2, 8'h55, 8'h11, 1'b0);
    req_valid = 4'b0110;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL restart_grant: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    lat = 1;
    while (!res_valid && lat < 10) begin tick(); lat++; end
    n_checks++;
    if (lat !== 3 || {res_data, res_carry, res_id} !== {8'h3B, 1'b1, 2'd1}) begin
      n_fail++; $display("FAIL restart_result: got lat=%0d data=%h carry=%b id=%0d expected 3/3b/1/1",
                         lat, res_data, res_carry, res_id);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_scheduler.md
# adder_scheduler

Time-multiplexes one shared `N_bit_adder` instance among `R` requesters in the FFT stage, e.g. butterfly add/sub lanes that cannot each afford a ripple adder on the TinyFPGA.
- Arbitration is round-robin, with a valid/ready handshake per requester.
- Subtraction runs as two passes through the same adder: two's-complement negate, then add.
- The result is held in an output register with valid/ready backpressure.

## Interface
- `N`, 8, operand/result width; passed to the internal `N_bit_adder`.
- `R`, 4, number of requesters (2..8); `IW = max(1, clog2(R))`.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  R  per-requester request valid.
- `req_ready`  out  R  per-requester accept; at most one bit high.
- `req_a`  in  R*N  operand A; requester i uses bits [i*N +: N].
- `req_b`  in  R*N  operand B; same packing.
- `req_sub`  in  R  1 = A−B, 0 = A+B.
- `res_valid`  out  1  result register holds a result.
- `res_data`  out  N  sum/difference, modulo 2^N.
- `res_carry`  out  1  add: carry out; sub: no-borrow flag (1 iff A ≥ B unsigned).
- `res_id`  out  IW  index of the requester that owns the result.
- `res_ready`  in  1  consumer accepts the result.

## Operation
- States: IDLE, NEG, ADD, HOLD.
- **IDLE:**
  - Grant goes to the first requester with `req_valid` high, searching from `ptr+1` upward with wrap.
  - `req_ready[g]` is combinational from `req_valid` and is high only in IDLE.
  - A requester must not make `req_valid` depend on `req_ready`.
  - Accept = `req_valid[g] & req_ready[g]`. On accept:
    - latch A, B, sub and id;
    - set `ptr <= g`;
    - go to NEG if sub, else to ADD.
  - No valid → stay in IDLE.
- **NEG** (sub only):
  - Adder inputs are (~B, 1).
  - Store the sum into the B register and the adder carry into `neg_c`.
  - Go to ADD.
- **ADD:**
  - Adder inputs are (A, Breg).
  - Register `res_data` = sum and set `res_valid` = 1; go to HOLD.
  - `res_carry` = carry_out for add, or carry_out | `neg_c` for sub. This covers B = 0, where ~0+1 wraps with carry.
- **HOLD:**
  - `res_data`, `res_carry` and `res_id` are stable while `res_valid` is high.
  - When `res_ready` is high: clear `res_valid` at that edge and go to IDLE.
  - No new request is accepted in HOLD.
- Adder input muxing is combinational from state. The adder is the only arithmetic resource; no second adder or `-` operator.
- Requester payload is sampled only at the accept edge. Later changes on `req_a`, `req_b` and `req_sub` are ignored.
- **Reset** (any state, including mid-NEG/ADD/HOLD):
  - state → IDLE, `ptr` → R−1 (requester 0 has first priority);
  - `res_valid` = 0, `res_data` = 0, `res_carry` = 0, `res_id` = 0;
  - the in-flight transaction is discarded;
  - `req_ready` = 0 while `reset` is high.

## Timing
- Accept at the end of cycle C:
  - add: ADD in C+1, `res_valid` high from C+2;
  - sub: NEG in C+1, ADD in C+2, `res_valid` high from C+3.
- `res_ready` high in the first valid cycle gives IDLE in the next cycle. Peak rate is one add per 3 cycles and one sub per 4 cycles.
- `res_ready` may be high before `res_valid`; it has no effect outside HOLD.
- A requester that drops `req_valid` before it is granted loses nothing; there is no request queuing.
- Fairness: with all R requesters continuously valid, each is served exactly once per R transactions.

## Test plan
- **Reset:** hold `reset` 2 cycles with all `req_valid` = 1.
  - During reset: `req_ready` = 0, `res_valid` = 0, `res_data` = 0x00.
  - First grant after release is requester 0.
- **Add with carry** (N=8, R=4):
  - req1 A=0x7F, B=0x01, add; accept at C → `res_valid` at C+2, `res_data` 0x80, `res_carry` 0, `res_id` 1.
  - A=0xFF, B=0x02 → 0x01, carry 1.
- **Sub:**
  - 0x05−0x07 → 0xFE, carry 0, valid at C+3.
  - 0x09−0x00 → 0x09, carry 1.
  - 0x07−0x07 → 0x00, carry 1.
- **Round robin:** all four requesters valid, `res_ready` = 1 → `res_id` sequence 0,1,2,3,0,1.
  - Then only req2 valid: req2 is served every 3 cycles.
- **Backpressure:** `res_ready` = 0 for 10 cycles in HOLD.
  - Result is stable and all `req_ready` = 0.
  - Result is released on the cycle `res_ready` rises.
- **Reset mid-operation:** assert `reset` in the NEG cycle of a sub.
  - `res_valid` never rises for that transaction.
  - The next request completes correctly with `res_id` reflecting the restart at requester 0 priority.
